// File: rtl/platform_scheduler_if.sv
// rtl/platform_scheduler_if.sv - frame, kill, read and status signals of the platform scheduler
interface platform_scheduler_if;
  logic       frame_clk;
  logic [7:0] scroll_amt;
  logic [1:0] difficulty;
  logic       kill_valid;
  logic [3:0] kill_idx;
  logic       kill_ready;
  logic [3:0] rd_idx;
  logic [8:0] rd_x;
  logic [8:0] rd_y;
  logic [2:0] rd_type;
  logic       busy;
  logic       scan_done;
  logic       respawn_pulse;
  logic       overrun;

  modport master (
    output frame_clk, scroll_amt, difficulty, kill_valid, kill_idx, rd_idx,
    input  kill_ready, rd_x, rd_y, rd_type, busy, scan_done, respawn_pulse, overrun
  );

  modport slave (
    input  frame_clk, scroll_amt, difficulty, kill_valid, kill_idx, rd_idx,
    output kill_ready, rd_x, rd_y, rd_type, busy, scan_done, respawn_pulse, overrun
  );
endinterface

// File: rtl/platform_scheduler.sv
// rtl/platform_scheduler.sv - 16-slot platform table with per-frame scroll, LFSR respawn and kill port
module platform_scheduler #(
  parameter int          SCREEN_H   = 480,
  parameter int          SPACING    = 30,
  parameter int          XMAX       = 400,
  parameter int          MAX_SCROLL = 60,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                 Clk,
  input logic                 Reset,
  platform_scheduler_if.slave bus
);

  typedef enum logic [1:0] {INIT, IDLE, SCROLL, DONE} state_t;

  localparam logic [9:0] H10   = 10'(SCREEN_H);
  localparam logic [8:0] XMAX9 = 9'(XMAX);
  localparam logic [7:0] MAXS8 = 8'(MAX_SCROLL);

  state_t      state;
  logic [3:0]  idx;
  logic [15:0] lfsr;
  logic [7:0]  s;
  logic        frame_clk_q;
  logic        busy, kill_ready, scan_done, respawn_pulse, overrun;

  logic [8:0]  tab_x    [16];
  logic [8:0]  tab_y    [16];
  logic [2:0]  tab_type [16];

  logic        tick, kill_fire, wrap;
  logic [15:0] lfsr_next;
  logic [8:0]  rand_x, init_y, new_y;
  logic [2:0]  rand_type;
  logic [9:0]  sum;

  assign tick      = bus.frame_clk & ~frame_clk_q;
  assign kill_fire = bus.kill_valid & kill_ready;
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign rand_x    = (lfsr[8:0] >= XMAX9) ? lfsr[8:0] - XMAX9 : lfsr[8:0];
  assign init_y    = 9'(SCREEN_H - SPACING * (int'(idx) + 1));
  assign sum       = {1'b0, tab_y[idx]} + {2'b00, s};
  assign wrap      = (sum >= H10);
  assign new_y     = wrap ? 9'(sum - H10) : sum[8:0];

  always_comb begin
    rand_type = 3'd0;
    case (bus.difficulty)
      2'd0:    rand_type = 3'd0;
      2'd1:    rand_type = (lfsr[1:0] == 2'b11) ? 3'd1 : 3'd0;
      default: begin
        case (lfsr[2:0])
          3'd0, 3'd1, 3'd2: rand_type = 3'd0;
          3'd3, 3'd4:       rand_type = 3'd1;
          3'd5, 3'd6:       rand_type = 3'd2;
          default:          rand_type = 3'd3;
        endcase
      end
    endcase
  end

  // Table contents survive reset; INIT rewrites every slot anyway.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == INIT) begin
        tab_x[idx]    <= rand_x;
        tab_y[idx]    <= init_y;
        tab_type[idx] <= 3'd0;
      end else if (state == SCROLL) begin
        tab_y[idx] <= new_y;
        if (wrap) begin
          tab_x[idx]    <= rand_x;
          tab_type[idx] <= rand_type;
        end
      end else if (state == IDLE && kill_fire) begin
        tab_type[bus.kill_idx] <= 3'd7;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= INIT;
      idx           <= 4'd0;
      lfsr          <= LFSR_SEED;
      s             <= 8'd0;
      frame_clk_q   <= 1'b0;
      busy          <= 1'b1;
      kill_ready    <= 1'b0;
      scan_done     <= 1'b0;
      respawn_pulse <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_clk_q   <= bus.frame_clk;
      scan_done     <= 1'b0;
      respawn_pulse <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        INIT: begin
          lfsr <= lfsr_next;
          idx  <= idx + 4'd1;
          if (idx == 4'd15) begin
            busy       <= 1'b0;
            kill_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        IDLE: begin
          if (tick) begin
            s          <= (bus.scroll_amt > MAXS8) ? MAXS8 : bus.scroll_amt;
            busy       <= 1'b1;
            kill_ready <= 1'b0;
            idx        <= 4'd0;
            state      <= SCROLL;
          end
        end
        SCROLL: begin
          lfsr          <= lfsr_next;
          idx           <= idx + 4'd1;
          respawn_pulse <= wrap;
          if (idx == 4'd15) begin
            busy      <= 1'b0;
            scan_done <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          kill_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy;
  assign bus.kill_ready    = kill_ready;
  assign bus.scan_done     = scan_done;
  assign bus.respawn_pulse = respawn_pulse;
  assign bus.overrun       = overrun;
  assign bus.rd_x          = tab_x[bus.rd_idx];
  assign bus.rd_y          = tab_y[bus.rd_idx];
  assign bus.rd_type       = tab_type[bus.rd_idx];

endmodule

// File: tb/tb_platform_scheduler.sv
// tb/tb_platform_scheduler.sv - self-checking bench for platform_scheduler
module tb_platform_scheduler;
  localparam int          SCREEN_H   = 480;
  localparam int          SPACING    = 30;
  localparam int          XMAX       = 400;
  localparam int          MAX_SCROLL = 60;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  platform_scheduler_if bus();

  platform_scheduler #(
    .SCREEN_H(SCREEN_H), .SPACING(SPACING), .XMAX(XMAX),
    .MAX_SCROLL(MAX_SCROLL), .LFSR_SEED(SEED)
  ) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  typedef struct {
    int amt;
    int pulses;
    int y0, y1, y2, y15;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mx[16], my[16], mt[16];
  int          seen[8];
  logic [15:0] ml;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int model_x(input logic [15:0] l);
    return int'(l[8:0]) % XMAX;
  endfunction

  function automatic int model_type(input logic [15:0] l, input int d);
    int v;
    v = int'(l);
    if (d == 0) return 0;
    if (d == 1) return (v % 4 == 3) ? 1 : 0;
    v = v % 8;
    if (v < 3) return 0;
    if (v < 5) return 1;
    if (v < 7) return 2;
    return 3;
  endfunction

  task automatic model_init();
    ml = SEED;
    for (int i = 0; i < 16; i++) begin
      my[i] = SCREEN_H - SPACING * (i + 1);
      mx[i] = model_x(ml);
      mt[i] = 0;
      ml    = lfsr_step(ml);
    end
  endtask

  task automatic model_frame(input int amt, input int d, output int pulses);
    int sc, y;
    sc     = (amt > MAX_SCROLL) ? MAX_SCROLL : amt;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      y = my[i] + sc;
      if (y >= SCREEN_H) begin
        my[i] = y - SCREEN_H;
        mx[i] = model_x(ml);
        mt[i] = model_type(ml, d);
        pulses++;
      end else begin
        my[i] = y;
      end
      ml = lfsr_step(ml);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      check($sformatf("%s_x%0d", tag, i), int'(bus.rd_x), mx[i]);
      check($sformatf("%s_y%0d", tag, i), int'(bus.rd_y), my[i]);
      check($sformatf("%s_type%0d", tag, i), int'(bus.rd_type), mt[i]);
      seen[int'(bus.rd_type)]++;
    end
    step();
  endtask

  task automatic do_reset(input int cycles);
    int n;
    rst            = 1'b1;
    bus.frame_clk  = 1'b0;
    bus.kill_valid = 1'b0;
    repeat (cycles) step();
    rst = 1'b0;
    check("rst_busy", int'(bus.busy), 1);
    check("rst_kill_ready", int'(bus.kill_ready), 0);
    check("rst_scan_done", int'(bus.scan_done), 0);
    check("rst_respawn", int'(bus.respawn_pulse), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    check("init_busy_cycles", n, 16);
    model_init();
    cmp_table("init");
  endtask

  task automatic do_frame(input int amt, input int d, output int pulses, output int done_step);
    bus.scroll_amt = 8'(amt);
    bus.difficulty = 2'(d);
    bus.frame_clk  = 1'b1;
    pulses         = 0;
    done_step      = 0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j == 1) begin
        bus.frame_clk  = 1'b0;
        bus.kill_valid = 1'b0;
        check("busy_rise", int'(bus.busy), 1);
      end
      if (bus.respawn_pulse) pulses++;
      if (bus.scan_done) done_step = j;
      if (done_step != 0 && j == done_step + 1) break;
    end
    check("scan_latency", done_step, 17);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   p, ds, mp, acc, nscan, k, d, amt;

    vecs[0] = '{10,  0, 460, 430, 400, 10};
    vecs[1] = '{40,  1, 10,  460, 430, 40};
    vecs[2] = '{255, 2, 30,  0,   450, 60};
    vecs[3] = '{60,  2, 30,  0,   450, 60};
    vecs[4] = '{0,   0, 450, 420, 390, 0};
    vecs[5] = '{29,  0, 479, 449, 419, 29};
    vecs[6] = '{30,  1, 0,   450, 420, 30};

    bus.frame_clk  = 1'b0;
    bus.scroll_amt = 8'd0;
    bus.difficulty = 2'd0;
    bus.kill_valid = 1'b0;
    bus.kill_idx   = 4'd0;
    bus.rd_idx     = 4'd0;

    foreach (vecs[v]) begin
      do_reset(3);
      do_frame(vecs[v].amt, 0, p, ds);
      check($sformatf("vec%0d_pulses", v), p, vecs[v].pulses);
      bus.rd_idx = 4'd0;  #1 check($sformatf("vec%0d_y0", v), int'(bus.rd_y), vecs[v].y0);
      bus.rd_idx = 4'd1;  #1 check($sformatf("vec%0d_y1", v), int'(bus.rd_y), vecs[v].y1);
      bus.rd_idx = 4'd2;  #1 check($sformatf("vec%0d_y2", v), int'(bus.rd_y), vecs[v].y2);
      bus.rd_idx = 4'd15; #1 check($sformatf("vec%0d_y15", v), int'(bus.rd_y), vecs[v].y15);
      model_frame(vecs[v].amt, 0, mp);
      cmp_table($sformatf("vec%0d", v));
    end

    // tick arriving mid-scan is dropped and latches overrun
    do_reset(3);
    bus.scroll_amt = 8'd10;
    bus.frame_clk  = 1'b1;
    nscan          = 0;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j == 1) bus.frame_clk = 1'b0;
      if (j == 5) bus.frame_clk = 1'b1;
      if (j == 6) bus.frame_clk = 1'b0;
      if (j == 4) check("overrun_before", int'(bus.overrun), 0);
      if (j == 7) check("overrun_set", int'(bus.overrun), 1);
      if (bus.scan_done) nscan++;
    end
    check("overrun_scan_count", nscan, 1);
    model_frame(10, 0, mp);
    cmp_table("overrun");
    do_frame(0, 0, p, ds);
    model_frame(0, 0, mp);
    check("overrun_sticky", int'(bus.overrun), 1);

    // kill in IDLE; same-cycle read still shows the old type
    check("kill_ready_idle", int'(bus.kill_ready), 1);
    bus.kill_idx   = 4'd3;
    bus.kill_valid = 1'b1;
    bus.rd_idx     = 4'd3;
    #1 check("kill_old_type", int'(bus.rd_type), mt[3]);
    step();
    bus.kill_valid = 1'b0;
    check("kill_new_type", int'(bus.rd_type), 7);
    mt[3] = 7;
    cmp_table("kill_idle");

    // kill held through a scan is accepted the cycle after DONE
    bus.scroll_amt = 8'd10;
    bus.frame_clk  = 1'b1;
    acc            = 0;
    for (int j = 1; j <= 25; j++) begin
      step();
      if (j == 1) bus.frame_clk = 1'b0;
      if (acc != 0 && j == acc + 1) bus.kill_valid = 1'b0;
      if (j == 2) begin
        bus.kill_idx   = 4'd5;
        bus.kill_valid = 1'b1;
      end
      if (bus.kill_valid && bus.kill_ready && acc == 0) acc = j;
    end
    check("kill_held_accept_step", acc, 18);
    model_frame(10, 0, mp);
    mt[5] = 7;
    cmp_table("kill_held");

    // kill and tick together: kill lands first, hidden slot then scrolls
    bus.kill_idx   = 4'd15;
    bus.kill_valid = 1'b1;
    do_frame(10, 0, p, ds);
    mt[15] = 7;
    model_frame(10, 0, mp);
    check("kill_tick_pulses", p, mp);
    cmp_table("kill_tick");

    // reset in the middle of a scan restarts INIT from the seed
    bus.scroll_amt = 8'd30;
    bus.frame_clk  = 1'b1;
    step();
    bus.frame_clk = 1'b0;
    repeat (5) step();
    do_reset(1);

    // easy difficulty: every respawn is green
    do_reset(3);
    for (int f = 0; f < 200; f++) begin
      amt = int'($urandom_range(0, 255));
      do_frame(amt, 0, p, ds);
      model_frame(amt, 0, mp);
      check("easy_pulses", p, mp);
      cmp_table("easy");
    end

    // hard difficulty: all four visible types occur, never hidden
    do_reset(3);
    foreach (seen[t]) seen[t] = 0;
    for (int f = 0; f < 200; f++) begin
      amt = int'($urandom_range(20, 255));
      do_frame(amt, 2, p, ds);
      model_frame(amt, 2, mp);
      check("hard_pulses", p, mp);
      cmp_table("hard");
    end
    for (int t = 0; t < 4; t++) check($sformatf("hard_seen_type%0d", t), int'(seen[t] > 0), 1);
    check("hard_seen_type7", seen[7], 0);

    // random difficulty with random kills, sometimes coincident with the tick
    do_reset(3);
    for (int f = 0; f < 80; f++) begin
      amt = int'($urandom_range(0, 255));
      d   = int'($urandom_range(0, 3));
      k   = int'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: begin
          bus.kill_idx   = 4'(k);
          bus.kill_valid = 1'b1;
          step();
          bus.kill_valid = 1'b0;
          mt[k] = 7;
        end
        1: begin
          bus.kill_idx   = 4'(k);
          bus.kill_valid = 1'b1;
          mt[k] = 7;
        end
        default: ;
      endcase
      do_frame(amt, d, p, ds);
      model_frame(amt, d, mp);
      check("mix_pulses", p, mp);
      cmp_table("mix");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
